// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// The TRAP state exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRPC,
    S_LUI
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // funct3 values the ALU decoder actually implements for R/I types
  function automatic logic alu_funct3_listed(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) ||
           (f3 == 3'b100) || (f3 == 3'b010);
  endfunction

  function automatic logic branch_funct3_listed(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-field inputs and datapath control outputs of the controller.
// The illegal flag is present only with MC_CTRL_ILLEGAL_TRAP_EN.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       lt;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] imm_source;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  modport master (
    input  opcode, funct3, funct7_5, zero, lt,
    output pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_source
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output opcode, funct3, funct7_5, zero, lt,
    input  pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_control, imm_source
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's coarse alu_op plus funct fields to the 3-bit ALU operation.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // opcode[5] separates R-type from I-type; addi ignores funct7_5
          3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b100:  alu_control = ALU_XOR;
          3'b010:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core; one instruction in flight.
// Optional MC_CTRL_ILLEGAL_TRAP_EN adds a sticky TRAP state and illegal flag.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  state_t     state_reg;
  state_t     state_next;
  alu_op_t    alu_op;
  logic       branch_taken;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_source;
  logic [2:0] alu_control;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    case (bus.funct3)
      3'b000:  branch_taken = bus.zero;
      3'b001:  branch_taken = !bus.zero;
      3'b100:  branch_taken = bus.lt;
      3'b101:  branch_taken = !bus.lt;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_source = IMM_I;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    case (state_reg)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // branch/jump target OldPC+imm is precomputed here into ALUOut
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_source = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE: begin
            state_next = S_EXECR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (!alu_funct3_listed(bus.funct3)) state_next = S_TRAP;
`endif
          end
          OP_ITYPE: begin
            state_next = S_EXECI;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (!alu_funct3_listed(bus.funct3)) state_next = S_TRAP;
`endif
          end
          OP_BRANCH: begin
            state_next = S_BRANCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (!branch_funct3_listed(bus.funct3)) state_next = S_TRAP;
`endif
          end
          OP_JAL:  state_next = S_JAL;
          OP_JALR: state_next = S_JALR;
          OP_LUI:  state_next = S_LUI;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default: state_next = S_TRAP;
`else
          default: state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_source = bus.opcode[5] ? IMM_S : IMM_I;
        state_next = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_source = IMM_I;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = branch_taken;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_source = IMM_I;
        state_next = S_JALRPC;
      end
      S_JALRPC: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        imm_source = IMM_U;
        state_next = S_ALUWB;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // reset suppresses any architectural write, even mid-instruction
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal   = 1'b0;
`endif
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7_5    (bus.funct7_5),
    .op_5        (bus.opcode[5]),
    .alu_control (alu_control)
  );

  assign bus.pc_write    = pc_write;
  assign bus.adr_src     = adr_src;
  assign bus.ir_write    = ir_write;
  assign bus.mem_write   = mem_write;
  assign bus.reg_write   = reg_write;
  assign bus.result_src  = result_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_control = alu_control;
  assign bus.imm_source  = imm_source;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal     = illegal;
`endif

endmodule
